// File: rtl/byte_uart_tx.sv
// Console UART transmitter: queues write-strobed bytes in a small FIFO and
// serialises each one as an 8N1 frame on txd at CLK_DIV clocks per bit.
module byte_uart_tx #(
   parameter int CLK_DIV = 434,
   parameter int FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [7:0]         in_byte,
   input  logic               in_byte_en,
   output logic               txd,
   output logic               busy,
   output logic               fifo_full,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   input  logic               ovf_clr
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int LW    = FIFO_AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);
   localparam logic [15:0]   BAUD_RELOAD = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic          txd_q, txd_d;
   logic [7:0]    shift_q, shift_d;
   logic [15:0]   baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    mem_q [DEPTH];

   logic [LW-1:0] level;
   logic          push;
   logic          pop;
   logic          baud_zero;

   // Pointers carry one extra bit so a full FIFO is distinguishable from empty.
   always_comb begin
      level      = wr_ptr_q - rd_ptr_q;
      fifo_full  = (level == FULL_LEVEL);
      push       = in_byte_en && !fifo_full;
      pop        = (state_q == IDLE) && (level != '0);
      baud_zero  = (baud_q == 16'd0);
      wr_ptr_d   = wr_ptr_q + LW'(push);
      rd_ptr_d   = rd_ptr_q + LW'(pop);
      overflow_d = overflow_q;
      if (in_byte_en && fifo_full) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         txd_q      <= 1'b1;
         shift_q    <= 8'd0;
         baud_q     <= 16'd0;
         bit_q      <= 3'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         txd_q      <= txd_d;
         shift_q    <= shift_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= in_byte;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pop) state_d = START;
         START:   if (baud_zero) state_d = DATA;
         DATA:    if (baud_zero && (bit_q == 3'd7)) state_d = STOP;
         STOP:    if (baud_zero) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Every bit boundary reloads the counter so each bit lasts exactly CLK_DIV cycles.
   always_comb begin
      txd_d   = txd_q;
      shift_d = shift_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               txd_d   = 1'b0;
               shift_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];
               baud_d  = BAUD_RELOAD;
            end else begin
               txd_d = 1'b1;
            end
         end
         START: begin
            if (baud_zero) begin
               txd_d  = shift_q[0];
               baud_d = BAUD_RELOAD;
               bit_d  = 3'd0;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         DATA: begin
            if (baud_zero) begin
               baud_d = BAUD_RELOAD;
               if (bit_q != 3'd7) begin
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end else begin
                  txd_d = 1'b1;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         STOP: begin
            if (!baud_zero) begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: begin
            txd_d = 1'b1;
         end
      endcase
   end

   assign txd        = txd_q;
   assign busy       = (state_q != IDLE) || (level != '0);
   assign fifo_level = level;
   assign overflow   = overflow_q;

endmodule

// File: doc/byte_uart_tx.md
Name: byte_uart_tx

Overview:
- Serial console transmitter that consumes the `out_byte`/`out_byte_en` write strobe produced by the CPU system's memory/IO decode.
- Buffers bytes in a small FIFO and shifts each one out on `txd` as 8N1 UART frames at a fixed divider.
- Sits directly downstream of the system top, so firmware console writes become a serial pin without stalling the CPU.

Parameters:
- CLK_DIV, 434: clock cycles per UART bit (50 MHz / 115200). Legal range 2..65535.
- FIFO_AW, 4: FIFO address width. Depth = 2**FIFO_AW = 16 entries.

Ports:
- clk  input  1  system clock; all logic on posedge.
- resetn  input  1  asynchronous, active-low reset.
- in_byte  input  8  byte to transmit; sampled when in_byte_en=1.
- in_byte_en  input  1  single-cycle write strobe; each high cycle is one byte.
- txd  output  1  serial output, idle high, registered.
- busy  output  1  high when FIFO is non-empty or a frame is in progress.
- fifo_full  output  1  FIFO holds 2**FIFO_AW entries.
- fifo_level  output  FIFO_AW+1  number of queued bytes, excluding the byte in the shifter.
- overflow  output  1  sticky; set when a byte is dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, resetn=0):
  - txd=1, busy=0, fifo_full=0, fifo_level=0, overflow=0.
  - FSM=IDLE, read/write pointers=0, baud counter=0, bit counter=0.
  - Reset applied mid-frame aborts the frame: txd returns high immediately and queued bytes are discarded.
- FIFO:
  - Circular buffer with FIFO_AW+1-bit pointers. Pointers wrap modulo 2**(FIFO_AW+1).
  - fifo_level = wr_ptr - rd_ptr. fifo_full = (level == 2**FIFO_AW).
  - Write: in_byte_en=1 and fifo_full=0 (registered value at that edge) stores in_byte.
  - If in_byte_en=1 and fifo_full=1, the byte is dropped and overflow is set. This applies even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: both happen and level is unchanged.
  - overflow set has priority over ovf_clr in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if level>0, pop the head into an 8-bit shifter, set txd<=0, load the baud counter with CLK_DIV-1, go to START. Otherwise txd<=1.
  - START: on baud counter==0, txd<=shifter[0], reload the counter, bit index<=0, go to DATA. Otherwise decrement.
  - DATA: on counter==0:
    - if bit index<7: shift right, txd<=next bit, index+1, reload the counter;
    - if bit index==7: txd<=1, reload the counter, go to STOP.
  - STOP: on counter==0, go to IDLE. Otherwise decrement.
  - Bits are sent LSB first.
- Timing:
  - Each of the start, 8 data and stop bits holds exactly CLK_DIV cycles.
  - Frame period is 10*CLK_DIV cycles plus 1 IDLE cycle between back-to-back frames.
  - Latency: with FIFO empty and FSM in IDLE, in_byte_en sampled at edge N gives the FIFO write at edge N. The pop happens at edge N+1 and txd goes low from edge N+1.
- busy = (state != IDLE) || (level != 0). It is combinational from registers.
- in_byte is never sampled when in_byte_en=0. No other input affects the FSM.

Test Plan:
- Use CLK_DIV=4 for the bench.
- Reset, then write 0x55 at edge N:
  - txd low from N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 each for 4 cycles, then stop bit high for 4 cycles.
  - busy falls at N+41; fifo_level returns to 0 at N+1.
- Write 0xA3 then 0x0F on consecutive cycles:
  - decode 0xA3 (LSB first 1,1,0,0,0,1,0,1) then 0x0F.
  - Second start bit begins exactly 41 cycles after the first.
- Write 18 bytes on consecutive cycles 0x00..0x11:
  - fifo_level reaches 16 and fifo_full=1.
  - 0x11 is dropped and overflow=1.
  - Decoded stream is 0x00..0x10 in order. Pulse ovf_clr and overflow returns to 0.
- Assert ovf_clr in the same cycle as a dropped write: overflow stays 1.
- Assert resetn=0 during the DATA state of a frame:
  - txd=1 immediately (async), fifo_level=0, busy=0.
  - After release, txd stays high with no partial frame resumed.
- Pointer wrap: stream 40 bytes with gaps so the FIFO never overflows.
  - All 40 are decoded in order, overflow stays 0, fifo_level returns to 0.
